// File: rtl/demux_sched.sv
// Registered 1-to-4 stream distributor: round-robin or addressed lane selection,
// one-deep output register per lane, per-lane delivered-word counters.
module demux_sched #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic               in_valid,
    input  logic [W-1:0]       in_data,
    input  logic [1:0]         in_dest,
    output logic               in_ready,
    output logic [3:0]         out_valid,
    output logic [4*W-1:0]     out_data,
    input  logic [3:0]         out_ready,
    output logic [1:0]         grant,
    output logic [4*CNT_W-1:0] cnt
);

    logic [W-1:0]     lane_data [4];
    logic [CNT_W-1:0] lane_cnt  [4];
    logic [1:0]       ptr;
    logic [1:0]       tgt;
    logic [3:0]       free;
    logic [3:0]       load;
    logic [3:0]       drain;
    logic             any_free;
    logic             accept;

    always_comb begin
        free     = ~out_valid | out_ready;
        tgt      = ptr;
        any_free = 1'b0;
        if (mode) begin
            tgt      = in_dest;
            any_free = free[in_dest];
        end else begin
            // Scan from the far end so the lane closest to ptr wins.
            for (int unsigned i = 4; i > 0; i--) begin
                if (free[2'(ptr + 2'(i - 1))]) tgt = 2'(ptr + 2'(i - 1));
            end
            any_free = |free;
        end
    end

    assign in_ready = any_free;
    assign accept   = in_valid & any_free;
    assign load     = accept ? (4'b0001 << tgt) : '0;
    assign drain    = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            ptr       <= '0;
            grant     <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                lane_data[k] <= '0;
                lane_cnt[k]  <= '0;
            end
        end else begin
            if (accept) begin
                grant <= tgt;
                if (!mode) ptr <= tgt + 2'd1;
            end
            for (int unsigned k = 0; k < 4; k++) begin
                if (load[k]) begin
                    lane_data[k] <= in_data;
                    out_valid[k] <= 1'b1;
                end else if (drain[k]) begin
                    out_valid[k] <= 1'b0;
                end
                if (drain[k]) lane_cnt[k] <= lane_cnt[k] + 1'b1;
            end
        end
    end

    always_comb begin
        out_data = '0;
        cnt      = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            out_data[k*W +: W]     = out_valid[k] ? lane_data[k] : '0;
            cnt[k*CNT_W +: CNT_W]  = lane_cnt[k];
        end
    end

endmodule

// File: tb/tb_demux_sched.sv
// Directed self-checking bench for demux_sched with hand-computed expectations.
module tb_demux_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic        in_valid;
    logic [3:0]  in_data;
    logic [1:0]  in_dest;
    logic        in_ready;
    logic [3:0]  out_valid;
    logic [15:0] out_data;
    logic [3:0]  out_ready;
    logic [1:0]  grant;
    logic [31:0] cnt;

    int n_tests = 0;
    int n_fail  = 0;

    demux_sched #(.W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant     (grant),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] lane(input int k);
        return out_data[k*4 +: 4];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = '0; out_ready = '0;
        step(); step();
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data",  32'(out_data),  32'h0);
        check("rst_grant", 32'(grant),     32'h0);
        check("rst_cnt",   cnt,            32'h0);
        check("rst_ready", 32'(in_ready),  32'h1);
        rst_n = 1'b1;

        // Round-robin stream, all consumers ready
        mode = 1'b0; out_ready = 4'hF; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 4'(i + 1);
            #1 check("rr_ready", 32'(in_ready), 32'h1);
            step();
            check("rr_valid", 32'(out_valid[i % 4]), 32'h1);
            check("rr_data",  32'(lane(i % 4)),      32'(i + 1));
            check("rr_grant", 32'(grant),            32'(i % 4));
        end
        in_valid = 1'b0;
        step();
        check("rr_cnt",   cnt,            32'h01010102);
        check("rr_empty", 32'(out_valid), 32'h0);

        // Skip busy lane: ptr=1, lane 1 held via addressed load
        mode = 1'b1; in_dest = 2'd1; in_data = 4'hB; in_valid = 1'b1; out_ready = 4'b1101;
        step();
        check("addr_grant", 32'(grant),   32'h1);
        check("addr_data",  32'(lane(1)), 32'hB);
        mode = 1'b0; in_data = 4'hA;
        #1 check("skip_ready", 32'(in_ready), 32'h1);
        step();
        check("skip_data",  32'(lane(2)),   32'hA);
        check("skip_grant", 32'(grant),     32'h2);
        check("skip_valid", 32'(out_valid), 32'h6);
        check("skip_hold",  32'(lane(1)),   32'hB);
        in_data = 4'hD; out_ready = 4'h0;
        step();
        check("ptr3_grant", 32'(grant),     32'h3);
        check("ptr3_valid", 32'(out_valid), 32'hE);
        check("ptr3_data",  32'(lane(3)),   32'hD);

        // Addressed stall on busy lane 3
        mode = 1'b1; in_dest = 2'd3; in_data = 4'hC;
        #1 check("stall_ready", 32'(in_ready), 32'h0);
        step();
        check("stall_data",  32'(lane(3)),   32'hD);
        check("stall_valid", 32'(out_valid), 32'hE);
        check("stall_cnt",   cnt,            32'h01010102);
        out_ready = 4'b1000;
        #1 check("unstall_ready", 32'(in_ready), 32'h1);
        step();
        check("reload_data",  32'(lane(3)),   32'hC);
        check("reload_valid", 32'(out_valid), 32'hE);
        check("reload_cnt",   cnt,            32'h02010102);

        // Full condition
        in_valid = 1'b0; out_ready = 4'hF;
        step();
        check("drain_valid", 32'(out_valid), 32'h0);
        check("drain_cnt",   cnt,            32'h03020202);
        out_ready = 4'h0; in_valid = 1'b1; mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_dest = 2'(k); in_data = 4'(6 + k);
            step();
        end
        check("full_valid", 32'(out_valid), 32'hF);
        check("full_data",  32'(out_data),  32'h9876);
        mode = 1'b0; in_data = 4'hE;
        for (int c = 0; c < 5; c++) begin
            #1 check("full_ready", 32'(in_ready), 32'h0);
            step();
            check("full_hold", {out_data, 12'h0, out_valid}, {16'h9876, 12'h0, 4'hF});
            check("full_cnt",  cnt, 32'h03020202);
        end
        out_ready = 4'b0100;
        #1 check("free2_ready", 32'(in_ready), 32'h1);
        step();
        check("free2_data",  32'(out_data),  32'h9E76);
        check("free2_grant", 32'(grant),     32'h2);
        check("free2_valid", 32'(out_valid), 32'hF);
        check("free2_cnt",   cnt,            32'h03030202);

        // Reset mid-stream with lanes 1 and 2 valid
        in_valid = 1'b0; out_ready = 4'hF;
        step();
        out_ready = 4'h0; mode = 1'b1; in_valid = 1'b1;
        in_dest = 2'd1; in_data = 4'h3;
        step();
        in_dest = 2'd2; in_data = 4'h4;
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'h6);
        check("pre_rst_cnt",   cnt,            32'h04040303);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_data",  32'(out_data),  32'h0);
        check("arst_grant", 32'(grant),     32'h0);
        check("arst_cnt",   cnt,            32'h0);
        step();
        rst_n = 1'b1; mode = 1'b0; out_ready = 4'hF; in_valid = 1'b1; in_data = 4'h5;
        step();
        check("post_rst_grant", 32'(grant),     32'h0);
        check("post_rst_data",  32'(lane(0)),   32'h5);
        check("post_rst_valid", 32'(out_valid), 32'h1);

        // Counter wrap on lane 0
        mode = 1'b1; in_dest = 2'd0; out_ready = 4'b0001;
        for (int i = 0; i < 255; i++) begin
            in_data = 4'(i);
            step();
        end
        check("wrap_255", cnt, 32'h000000FF);
        in_valid = 1'b0;
        step();
        check("wrap_0",     cnt,            32'h0);
        check("wrap_valid", 32'(out_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
